// File: rtl/fp_to_int_pipe.sv
// Pipelined IEEE-754 binary32 to INT_W-bit integer converter with rounding modes and saturation.
// Define FTOI_FLAGS_EN to drive {invalid, inexact} on out_flags; otherwise out_flags reads 2'b00.
module fp_to_int_pipe #(
    parameter int unsigned INT_W  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [1:0]       in_rm,
    input  logic             in_unsigned,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_y,
    output logic [1:0]       out_flags
);

    localparam int unsigned MW = 24;
    localparam int unsigned PW = ((INT_W > MW) ? INT_W : MW) + 2;
    localparam int unsigned HUGE_E = 127 + INT_W;

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RZ  = 2'd1;
    localparam logic [1:0] RM_RDN = 2'd2;
    localparam logic [1:0] RM_RUP = 2'd3;

    localparam logic [INT_W-1:0] U_MAX = '1;
    localparam logic [INT_W-1:0] S_MAX = U_MAX >> 1;
    localparam logic [INT_W-1:0] S_MIN = ~S_MAX;
    localparam logic [PW-1:0]    S_LIM = PW'(1) << (INT_W - 1);
    localparam logic [PW-1:0]    U_LIM = PW'(1) << INT_W;

    logic en;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Decode and align: integer magnitude plus guard/sticky from the right shift.
    logic          a_s;
    logic [7:0]    a_e;
    logic [22:0]   a_f;
    logic [23:0]   a_m;
    logic [7:0]    a_ls;
    logic [7:0]    a_rs;
    logic [4:0]    a_rs_c;
    logic [48:0]   a_rwin;
    logic          d_nan;
    logic          d_huge;
    logic [PW-1:0] d_mag;
    logic          d_g;
    logic          d_st;

    always_comb begin
        a_s    = in_x[31];
        a_e    = in_x[30:23];
        a_f    = in_x[22:0];
        a_m    = {1'b1, a_f};
        a_ls   = a_e - 8'd150;
        a_rs   = 8'd150 - a_e;
        // Any shift past 25 leaves only sticky, so clamping keeps the window small.
        a_rs_c = (a_rs > 8'd25) ? 5'd25 : a_rs[4:0];
        a_rwin = {a_m, 25'd0} >> a_rs_c;
        d_nan  = (a_e == 8'hFF) && (|a_f);
        d_huge = ({1'b0, a_e} >= 9'(HUGE_E));
        d_mag  = '0;
        d_g    = 1'b0;
        d_st   = 1'b0;
        if (a_e == 8'd0) begin
            d_mag = '0;
        end else if (a_e >= 8'd150) begin
            d_mag = PW'(a_m) << a_ls;
        end else begin
            d_mag = PW'(a_rwin[48:25]);
            d_g   = a_rwin[24];
            d_st  = |a_rwin[23:0];
        end
    end

    logic          p_valid;
    logic          p_s;
    logic [1:0]    p_rm;
    logic          p_uns;
    logic          p_nan;
    logic          p_huge;
    logic [PW-1:0] p_mag;
    logic          p_g;
    logic          p_st;

    if (STAGES >= 2) begin : g_reg_a
        always_ff @(posedge sys_clk) begin
            if (!rstn) begin
                p_valid <= 1'b0;
            end else if (en) begin
                p_valid <= in_valid;
                p_s     <= a_s;
                p_rm    <= in_rm;
                p_uns   <= in_unsigned;
                p_nan   <= d_nan;
                p_huge  <= d_huge;
                p_mag   <= d_mag;
                p_g     <= d_g;
                p_st    <= d_st;
            end
        end
    end else begin : g_pass_a
        always_comb begin
            p_valid = in_valid;
            p_s     = a_s;
            p_rm    = in_rm;
            p_uns   = in_unsigned;
            p_nan   = d_nan;
            p_huge  = d_huge;
            p_mag   = d_mag;
            p_g     = d_g;
            p_st    = d_st;
        end
    end

    // Round the magnitude, range-check against the selected bound, then apply the sign.
    logic             b_inx;
    logic             b_inc;
    logic [PW-1:0]    b_rmag;
    logic [PW-1:0]    b_neg;
    logic             b_sat;
    logic [INT_W-1:0] b_sat_y;
    logic [INT_W-1:0] b_y;

    always_comb begin
        b_inx   = p_g | p_st;
        b_inc   = 1'b0;
        b_sat   = 1'b0;
        b_sat_y = '0;
        case (p_rm)
            RM_RNE:  b_inc = p_g & (p_st | p_mag[0]);
            RM_RZ:   b_inc = 1'b0;
            RM_RDN:  b_inc = p_s & b_inx;
            RM_RUP:  b_inc = ~p_s & b_inx;
            default: b_inc = 1'b0;
        endcase
        b_rmag = p_mag + PW'(b_inc);
        b_neg  = PW'(0) - b_rmag;
        if (p_nan) begin
            b_sat   = 1'b1;
            b_sat_y = p_uns ? U_MAX : S_MAX;
        end else if (p_uns) begin
            if (p_s) begin
                if (p_huge || (b_rmag != '0)) begin
                    b_sat   = 1'b1;
                    b_sat_y = '0;
                end
            end else if (p_huge || (b_rmag >= U_LIM)) begin
                b_sat   = 1'b1;
                b_sat_y = U_MAX;
            end
        end else begin
            if (p_s) begin
                if (p_huge || (b_rmag > S_LIM)) begin
                    b_sat   = 1'b1;
                    b_sat_y = S_MIN;
                end
            end else if (p_huge || (b_rmag >= S_LIM)) begin
                b_sat   = 1'b1;
                b_sat_y = S_MAX;
            end
        end
        if (b_sat) begin
            b_y = b_sat_y;
        end else if (p_s) begin
            b_y = b_neg[INT_W-1:0];
        end else begin
            b_y = b_rmag[INT_W-1:0];
        end
    end

    logic             q_valid;
    logic [INT_W-1:0] q_y;

    if (STAGES >= 3) begin : g_reg_b
        always_ff @(posedge sys_clk) begin
            if (!rstn) begin
                q_valid <= 1'b0;
            end else if (en) begin
                q_valid <= p_valid;
                q_y     <= b_y;
            end
        end
    end else begin : g_pass_b
        always_comb begin
            q_valid = p_valid;
            q_y     = b_y;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_y     <= '0;
        end else if (en) begin
            out_valid <= q_valid;
            if (q_valid) begin
                out_y <= q_y;
            end
        end
    end

`ifdef FTOI_FLAGS_EN
    logic [1:0] b_flags;
    logic [1:0] q_flags;

    assign b_flags = {b_sat, ~b_sat & b_inx};

    if (STAGES >= 3) begin : g_flag_b
        always_ff @(posedge sys_clk) begin
            if (!rstn) begin
                q_flags <= 2'b00;
            end else if (en) begin
                q_flags <= b_flags;
            end
        end
    end else begin : g_flag_pass
        assign q_flags = b_flags;
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            out_flags <= 2'b00;
        end else if (en && q_valid) begin
            out_flags <= q_flags;
        end
    end
`else
    assign out_flags = 2'b00;
`endif

endmodule
